// File: rtl/hilo_div_unit.sv
// Iterative restoring divider for div/divu: quotient to LO, remainder to HI.
// One quotient bit per cycle, with sign fix-up in a final cycle.
module hilo_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;
    logic             dbz;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        shifted   = {rem, quo[WIDTH-1]};
        diff      = shifted - {1'b0, dvsr};
        a_mag     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        stall_req = busy | ((state == IDLE) & start & ~cancel);
        hilo_we   = done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dbz    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rem   <= '0;
                            quo   <= a_mag;
                            dvsr  <= b_mag;
                            cnt   <= '0;
                            q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg <= is_signed & dividend[WIDTH-1];
                            dbz   <= (divisor == '0);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        // diff[WIDTH] set means the trial subtract went negative: restore
                        rem   <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        quo   <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                        cnt   <= cnt + CNT_W'(1);
                        // counter reaches WIDTH on this edge
                        if (cnt == CNT_W'(WIDTH - 1))
                            state <= FIX;
                    end
                    FIX: begin
                        // with a zero divisor the remainder path already yields the dividend
                        lo_out <= dbz ? '1 : (q_neg ? -quo : quo);
                        hi_out <= r_neg ? -rem : rem;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: directed plan cases plus random div/divu,
// checked against an arithmetic reference model by an independent monitor.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        cancel = 1'b0;
    logic        busy, stall_req, done, hilo_we;
    logic [31:0] hi_out, lo_out;

    hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .cancel(cancel),
        .busy(busy), .stall_req(stall_req), .done(done), .hilo_we(hilo_we),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb_, q, r;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
            return;
        end
        if (s) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
        end else begin
            sa  = longint'({32'd0, a});
            sb_ = longint'({32'd0, b});
        end
        q  = sa / sb_;
        r  = sa % sb_;
        lo = q[31:0];
        hi = r[31:0];
    endfunction

    // monitor: pops the scoreboard on every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                chk("hilo_we", {31'd0, hilo_we}, 32'd1);
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("lo_out", lo_out, e.lo);
                    chk("hi_out", hi_out, e.hi);
                    chk("latency", cyc, e.cyc);
                end
            end
        end
    end

    // called at a negedge; returns at the negedge after the launch edge
    task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        exp_t e;
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        if (expect_done) begin
            ref_div(s, a, b, e.hi, e.lo);
            e.cyc   = cyc + 34;
            last_hi = e.hi;
            last_lo = e.lo;
            sb.push_back(e);
        end
        #1;
        chk("stall_req_launch", {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk("busy_after_launch", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input bit poke);
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (poke && n == 5) begin
                start     = 1'b1;
                is_signed = $urandom;
                dividend  = $urandom;
                divisor   = $urandom_range(1, 9);
            end else begin
                start = 1'b0;
            end
        end
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL done_timeout: got no done within 60 cycles expected done");
        end
    endtask

    initial begin
        logic [31:0] a, b;
        bit s;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // divu 100/7 with busy window check
        launch(1'b0, 32'd100, 32'd7, 1'b1);
        repeat (32) @(negedge clk);
        chk("busy_edge32", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("done_at_33", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("done_pulse_width", {31'd0, done}, 32'd0);

        launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);          wait_done(1'b0); @(negedge clk);
        launch(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);          wait_done(1'b0); @(negedge clk);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  wait_done(1'b0); @(negedge clk);
        launch(1'b0, 32'd5, 32'd0, 1'b1);                  wait_done(1'b0); @(negedge clk);
        launch(1'b1, 32'hFFFF_FF00, 32'd0, 1'b1);          wait_done(1'b0); @(negedge clk);

        // cancel mid-operation: no done, outputs keep prior values
        launch(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("busy_after_cancel", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("hi_kept_cancel", hi_out, last_hi);
        chk("lo_kept_cancel", lo_out, last_lo);

        // start with cancel in IDLE launches nothing
        start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
        #1 chk("stall_start_cancel", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("busy_start_cancel", {31'd0, busy}, 32'd0);

        launch(1'b0, 32'd9, 32'd3, 1'b1);
        wait_done(1'b0);
        // back-to-back launch in the done cycle
        launch(1'b0, 32'd1000, 32'd33, 1'b1);
        wait_done(1'b0);
        @(negedge clk);

        // async reset mid-op
        launch(1'b1, 32'hDEAD_BEEF, 32'd17, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_stall", {31'd0, stall_req}, 32'd0);
        chk("arst_hi", hi_out, 32'd0);
        chk("arst_lo", lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(1'b0, 32'd20, 32'd6, 1'b1);
        wait_done(1'b0);
        @(negedge clk);

        // random div/divu
        for (int i = 0; i < 40; i++) begin
            s = $urandom;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            launch(s, a, b, 1'b1);
            wait_done($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        begin
            int n = 0;
            while ((sb.size() != 0 || busy) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (sb.size() != 0) begin
                nvec++;
                nerr++;
                $display("FAIL drain: got %0d pending results expected 0", sb.size());
            end
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle iterative divider in the EX stage of the pipelined processor.
- Executes div/divu: quotient goes to LO, remainder goes to HI.
- Feeds the register file's hi/lo registers through a one-cycle write strobe.
- Holds `stall_req` high so the pipeline freezes while a division is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request from decode/EX; sampled only in IDLE
- is_signed  input  1  1 = div (two's complement), 0 = divu
- dividend  input  WIDTH  rs operand
- divisor  input  WIDTH  rt operand
- cancel  input  1  pipeline flush; aborts an in-flight divide
- busy  output  1  divide in progress
- stall_req  output  1  busy OR (start AND NOT cancel in IDLE); combinational
- done  output  1  one-cycle pulse; results valid
- hilo_we  output  1  equals done; write strobe to hi/lo
- hi_out  output  WIDTH  remainder; held until the next done
- lo_out  output  WIDTH  quotient; held until the next done

Behaviour:
- Reset (async, rst_n=0):
  - State forced to IDLE.
  - busy=0, done=0, hilo_we=0, hi_out=0, lo_out=0.
  - Counter and working registers cleared.
- States:
  - IDLE -> RUN: on start=1 and cancel=0.
  - RUN -> FIX: when the counter reaches WIDTH.
  - FIX -> IDLE: always, one cycle.
  - Any state -> IDLE: cancel=1 takes priority over everything.
- Edge 0 (start sampled in IDLE):
  - Latch magnitudes: |dividend|, |divisor| when is_signed=1, raw values otherwise.
  - Latch quotient-negate = sign(dividend) XOR sign(divisor), only when signed.
  - Latch remainder-negate = sign(dividend), only when signed.
  - Latch a div-by-zero flag (divisor==0).
  - Partial remainder <= 0; counter <= 0; busy <= 1.
- Edges 1..WIDTH (RUN), restoring division, one quotient bit per edge, MSB first:
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtract.
  - If non-negative, commit the subtraction and set quo[0]=1.
  - Increment the counter.
- Edge WIDTH+1 (FIX):
  - Apply signs: lo_out <= quo, negated if quotient-negate; hi_out <= rem, negated if remainder-negate.
  - done <= 1, busy <= 0.
  - Total latency: start sample to done high = WIDTH+1 edges (33 for WIDTH=32).
  - done and hilo_we drop on the following edge.
- Divide by zero:
  - Same latency.
  - lo_out = all ones; hi_out = original dividend, for both div and divu.
- Signed overflow (-2^31 / -1): lo_out = 0x80000000, hi_out = 0. This falls out of the magnitude path and needs no special case.
- Remainder takes the sign of the dividend; the quotient truncates toward zero.
- start while busy or in FIX: ignored; not queued.
- cancel:
  - In RUN or FIX: next edge goes to IDLE with busy=0, no done pulse, hi_out/lo_out unchanged.
  - start and cancel together in IDLE: no operation is launched.
- Operands are captured at edge 0; later changes on dividend/divisor do not affect the result.
- Back-to-back operation: start may be asserted in the cycle done is high (state is IDLE); the new operation launches on that edge.

Test Plan:
- divu 100/7, start at edge 0:
  - busy=1 for edges 0..32; done/hilo_we high for exactly one cycle after edge 33.
  - lo_out=0x0000000E, hi_out=0x00000002.
- div -7/2 (0xFFFFFFF9 / 0x00000002): lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- div 7/-2: lo_out=0xFFFFFFFD, hi_out=0x00000001.
- div 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0.
- divu 5/0: lo_out=0xFFFFFFFF, hi_out=0x00000005; latency unchanged at 33 edges.
- Cancel and back-to-back:
  - Start 100/7, assert cancel at edge 10: busy=0 after edge 11, no done, hi_out/lo_out keep prior values.
  - Immediately start 9/3: lo_out=3, hi_out=0.
  - Start a second op in the done cycle: it launches without a gap.
- Reset mid-op: drop rst_n at edge 15 of a divide.
  - All outputs are 0 asynchronously, before the next clk edge.
  - After release, start 20/6 -> lo_out=3, hi_out=2.
